// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receive path.
// Parity modes, receiver states and error-flag bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_e;

   localparam int ERR_FRAME  = 0;
   localparam int ERR_PARITY = 1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy and sticky overflow.
// Pointers carry an extra MSB so full and empty can be told apart.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic [AW:0]      level,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign level = wptr - rptr;
   assign valid = (wptr != rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

   // A pop frees the slot a same-cycle push needs when full.
   assign do_pop  = pop && valid && !clr;
   assign do_push = push && !clr && (!full || do_pop);

   assign rdata = valid ? mem[rptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_pop)
            rptr <= rptr + 1'b1;
         if (do_push)
            wptr <= wptr + 1'b1;
         if (push && !do_push)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst)
         mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing feeding an FWFT FIFO.
// Frame settings are latched at start-bit detection.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DIV_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rx_i,
   input  logic [DIV_W-1:0]              divider_i,
   input  logic [1:0]                    parity_mode_i,
   input  logic                          two_stop_i,
   output logic [DATA_BITS-1:0]          rdata_o,
   output logic [1:0]                    rerr_o,
   output logic                          rvalid_o,
   input  logic                          rready_i,
   output logic                          overflow_o,
   input  logic                          clr_i,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   rx_state_e              state;
   logic [DIV_W-1:0]       cnt;
   logic [DIV_W-1:0]       div;
   logic [3:0]             nbit;
   logic [DATA_BITS-1:0]   shreg;
   parity_mode_e           pmode;
   logic                   two;
   logic                   stop_n;
   logic                   perr;
   logic                   ferr;
   logic                   ferr_now;
   logic [1:0]             err_now;
   logic                   tick;
   logic                   push;
   logic [DATA_BITS+1:0]   pdata;
   logic [DATA_BITS+1:0]   fdata;

   assign rxs      = sync[SYNC_STAGES-1];
   assign tick     = (cnt == '0);
   assign busy_o   = (state != IDLE);
   assign ferr_now = ferr | ~rxs;

   always_comb begin
      err_now             = '0;
      err_now[ERR_FRAME]  = ferr_now;
      err_now[ERR_PARITY] = perr;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         sync <= '1;
      else
         sync <= {sync[SYNC_STAGES-2:0], rx_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         div    <= '0;
         nbit   <= '0;
         shreg  <= '0;
         pmode  <= PAR_NONE;
         two    <= 1'b0;
         stop_n <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         push   <= 1'b0;
         pdata  <= '0;
      end else begin
         push <= 1'b0;
         if (!tick)
            cnt <= cnt - 1'b1;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state  <= START;
                  cnt    <= divider_i >> 1;
                  div    <= divider_i;
                  two    <= two_stop_i;
                  pmode  <= (parity_mode_i == 2'b11) ?
                            PAR_NONE :
                            parity_mode_e'(parity_mode_i);
                  nbit   <= '0;
                  stop_n <= 1'b0;
                  perr   <= 1'b0;
                  ferr   <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= div - 1'b1;
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  cnt   <= div - 1'b1;
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  if (nbit == LAST_BIT) begin
                     nbit  <= '0;
                     state <= (pmode == PAR_NONE) ?
                              STOP : PARITY;
                  end else begin
                     nbit <= nbit + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  cnt   <= div - 1'b1;
                  perr  <= (^shreg ^ rxs) !=
                           (pmode == PAR_ODD);
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  cnt <= div - 1'b1;
                  if (two && !stop_n) begin
                     stop_n <= 1'b1;
                     ferr   <= ferr_now;
                  end else begin
                     push  <= 1'b1;
                     pdata <= {err_now, shreg};
                     // A framing error on all-zero data is a line break.
                     state <= (ferr_now && shreg == '0) ?
                              BREAK_WAIT : IDLE;
                  end
               end
            end
            BREAK_WAIT: begin
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      (clr_i),
      .push     (push),
      .wdata    (pdata),
      .pop      (rready_i),
      .rdata    (fdata),
      .valid    (rvalid_o),
      .level    (level_o),
      .overflow (overflow_o)
   );

   assign rdata_o = fdata[DATA_BITS-1:0];
   assign rerr_o  = fdata[DATA_BITS+1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8-bit frames, depth-4 FIFO.
// Frames are bit-banged on rx and checked at the FIFO head.
module tb_uart_rx_fifo;

   localparam int DEPTH = 4;
   localparam int DIV   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [31:0] divider;
   logic [1:0]  pm;
   logic        two;
   logic [7:0]  rdata;
   logic [1:0]  rerr;
   logic        rvalid;
   logic        rready;
   logic        overflow;
   logic        clr;
   logic        busy;
   logic [2:0]  level;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_q[$];
   int         mcount;
   logic       exp_ovf;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DATA_BITS   (8),
      .FIFO_DEPTH  (DEPTH),
      .DIV_W       (32),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_i          (rx),
      .divider_i     (divider),
      .parity_mode_i (pm),
      .two_stop_i    (two),
      .rdata_o       (rdata),
      .rerr_o        (rerr),
      .rvalid_o      (rvalid),
      .rready_i      (rready),
      .overflow_o    (overflow),
      .clr_i         (clr),
      .busy_o        (busy),
      .level_o       (level)
   );

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [9:0] e);
      if (mcount < DEPTH) begin
         exp_q.push_back(e);
         mcount++;
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int pb,
                             input logic s1, input logic s2);
      logic [1:0] e;
      logic       p;
      e = '0;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pb >= 0) begin
         p = (pb != 0);
         drive_bit(p);
         if (pm == 2'b01) e[1] = ((^d) ^ p) != 1'b0;
         if (pm == 2'b10) e[1] = ((^d) ^ p) != 1'b1;
      end
      drive_bit(s1);
      e[0] = ~s1;
      if (two) begin
         drive_bit(s2);
         e[0] = e[0] | ~s2;
      end
      model_push({e, d});
   endtask

   task automatic pop_entry(output logic [9:0] got, output bit ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (rvalid) begin
            got    = {rerr, rdata};
            ok     = 1'b1;
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = 1'b0;
            mcount--;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rvalid, overflow, busy} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000",
                  {rvalid, overflow, busy});
      end
      checks++;
      if ({rerr, rdata} !== 10'h000) begin
         failures++;
         $display("FAIL reset_data got=%h exp=000", {rerr, rdata});
      end
      checks++;
      if (level !== 3'd0) begin
         failures++;
         $display("FAIL reset_level got=%0d exp=0", level);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_8n1();
      logic [9:0] got;
      logic [9:0] e;
      bit         ok;
      pm  = 2'b00;
      two = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(e_bit(8'hA5, i));
      rx = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (rvalid !== 1'b0) begin
         failures++;
         $display("FAIL 8n1_early_valid got=%b exp=0", rvalid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rvalid !== 1'b1) begin
         failures++;
         $display("FAIL 8n1_valid_latency got=%b exp=1", rvalid);
      end
      repeat (DIV) @(posedge clk);
      #1;
      model_push({2'b00, 8'hA5});
      while (exp_q.size() > 0) begin
         pop_entry(got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL 8n1_entry got=%h exp=%h ok=%0d", got, e, ok);
         end
      end
      checks++;
      if (level !== 3'd0) begin
         failures++;
         $display("FAIL 8n1_level_after_pop got=%0d exp=0", level);
      end
   endtask

   function automatic logic e_bit(input logic [7:0] d, input int i);
      return d[i];
   endfunction

   task automatic test_parity();
      logic [9:0] got;
      logic [9:0] e;
      bit         ok;
      pm = 2'b01;
      send_frame(8'h07, 1, 1'b1, 1'b1);
      drive_bit(1'b1);
      send_frame(8'h07, 0, 1'b1, 1'b1);
      drive_bit(1'b1);
      pm = 2'b10;
      send_frame(8'h07, 0, 1'b1, 1'b1);
      drive_bit(1'b1);
      send_frame(8'h07, 1, 1'b1, 1'b1);
      drive_bit(1'b1);
      while (exp_q.size() > 0) begin
         pop_entry(got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL parity_entry got=%h exp=%h ok=%0d",
                     got, e, ok);
         end
      end
      pm = 2'b00;
   endtask

   task automatic test_two_stop();
      logic [9:0] got;
      logic [9:0] e;
      bit         ok;
      two = 1'b1;
      send_frame(8'h3C, -1, 1'b1, 1'b0);
      rx = 1'b0;
      repeat (20 * DIV) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL break_busy_mid got=%b exp=1", busy);
      end
      repeat (10 * DIV) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL break_busy_hold got=%b exp=1", busy);
      end
      model_push({2'b01, 8'h00});
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL break_release got=%b exp=0", busy);
      end
      checks++;
      if (level !== 3'(mcount)) begin
         failures++;
         $display("FAIL break_level got=%0d exp=%0d", level, mcount);
      end
      while (exp_q.size() > 0) begin
         pop_entry(got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL two_stop_entry got=%h exp=%h ok=%0d",
                     got, e, ok);
         end
      end
      two = 1'b0;
      drive_bit(1'b1);
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_start got=%b exp=1", busy);
      end
      repeat (3 * DIV) @(posedge clk);
      #1;
      checks++;
      if ({busy, rvalid, level} !== 5'b0) begin
         failures++;
         $display("FAIL glitch_idle got=%b exp=00000",
                  {busy, rvalid, level});
      end
   endtask

   task automatic test_overflow();
      for (int v = 1; v <= 5; v++) begin
         send_frame(8'(v), -1, 1'b1, 1'b1);
         drive_bit(1'b1);
      end
      checks++;
      if (level !== 3'(mcount)) begin
         failures++;
         $display("FAIL ovf_level got=%0d exp=%0d", level, mcount);
      end
      checks++;
      if (overflow !== exp_ovf) begin
         failures++;
         $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf);
      end
      checks++;
      if (exp_q.size() == 0 || {rerr, rdata} !== exp_q[0]) begin
         failures++;
         $display("FAIL ovf_head got=%h exp=%h", {rerr, rdata},
                  exp_q.size() ? exp_q[0] : 10'h3FF);
      end
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      exp_q.delete();
      mcount  = 0;
      exp_ovf = 1'b0;
      checks++;
      if ({level, overflow, rvalid} !== {3'(mcount), exp_ovf, 1'b0}) begin
         failures++;
         $display("FAIL ovf_clear got=%b exp=00000",
                  {level, overflow, rvalid});
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] got;
      logic [9:0] e;
      bit         ok;
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy got=%b exp=1", busy);
      end
      rst = 1'b1;
      rx  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_idle got=%b exp=0", busy);
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      send_frame(8'h66, -1, 1'b1, 1'b1);
      checks++;
      if (level !== 3'(mcount)) begin
         failures++;
         $display("FAIL rst_mid_level got=%0d exp=%0d", level, mcount);
      end
      while (exp_q.size() > 0) begin
         pop_entry(got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL rst_mid_entry got=%h exp=%h ok=%0d",
                     got, e, ok);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] got;
      logic [9:0] e;
      bit         ok;
      pm = 2'b10;
      for (int k = 0; k < 3; k++)
         send_frame(8'($urandom_range(255)), int'($urandom_range(1)),
                    1'b1, 1'b1);
      while (exp_q.size() > 0) begin
         pop_entry(got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL b2b_entry got=%h exp=%h ok=%0d", got, e, ok);
         end
      end
      checks++;
      if (level !== 3'd0) begin
         failures++;
         $display("FAIL b2b_level got=%0d exp=0", level);
      end
      pm = 2'b00;
   endtask

   initial begin
      rst     = 1'b1;
      rx      = 1'b1;
      divider = 32'(DIV);
      pm      = 2'b00;
      two     = 1'b0;
      rready  = 1'b0;
      clr     = 1'b0;
      mcount  = 0;
      exp_ovf = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_two_stop();
      test_glitch();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
